// File: rtl/icache_direct_if.sv
// ---------------------------------------------------------------------------
// icache_direct_if
// Bundles the fetch-side and memory-side signals of icache_direct.
//   Fetch side : Instr_address_fIF, Flush (to cache)
//                Instr1_2IF, ICache_busy_2IF (from cache)
//   Memory side: Mem_data_fMEM, Mem_valid_fMEM (to cache)
//                Mem_req_2MEM, Mem_addr_2MEM (from cache)
//   Statistics : Hit_count, Miss_count (from cache)
// Modports:
//   slave  - the cache itself
//   master - whatever drives fetch addresses and answers line fills
// ---------------------------------------------------------------------------
interface icache_direct_if;
  logic [31:0] Instr_address_fIF;
  logic [31:0] Instr1_2IF;
  logic        ICache_busy_2IF;
  logic        Flush;
  logic        Mem_req_2MEM;
  logic [31:0] Mem_addr_2MEM;
  logic [31:0] Mem_data_fMEM;
  logic        Mem_valid_fMEM;
  logic [31:0] Hit_count;
  logic [31:0] Miss_count;

  modport slave (
    input  Instr_address_fIF,
    input  Flush,
    input  Mem_data_fMEM,
    input  Mem_valid_fMEM,
    output Instr1_2IF,
    output ICache_busy_2IF,
    output Mem_req_2MEM,
    output Mem_addr_2MEM,
    output Hit_count,
    output Miss_count
  );

  modport master (
    output Instr_address_fIF,
    output Flush,
    output Mem_data_fMEM,
    output Mem_valid_fMEM,
    input  Instr1_2IF,
    input  ICache_busy_2IF,
    input  Mem_req_2MEM,
    input  Mem_addr_2MEM,
    input  Hit_count,
    input  Miss_count
  );
endinterface

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
// Direct-mapped, read-only instruction cache. Lookup is combinational: a hit
// returns the instruction word in the same cycle, a miss raises
// ICache_busy_2IF and fills the whole line from memory through a
// request/valid handshake, beats arriving in ascending word order.
//
// Parameters:
//   LINE_WORDS - words per line (power of two, 2..16)
//   NUM_LINES  - number of lines (power of two, 4..1024)
//
// Ports:
//   CLK   - clock, all state changes on posedge
//   RESET - asynchronous, active-low reset
//   bus   - icache_direct_if.slave (fetch, memory and statistics signals)
//
// Optional feature:
//   ICACHE_STATS_EN - when defined, Hit_count / Miss_count are live 32-bit
//                     wrapping counters; otherwise both are tied to zero.
//
// FSM:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | lookups active; a miss (without Flush) launches a line fill
//   FILL    | Mem_req_2MEM high, collecting LINE_WORDS beats into the line
// ---------------------------------------------------------------------------
module icache_direct #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  icache_direct_if.slave  bus
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int IDX_LSB = 2 + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]           state_q,    state_d;
  logic [NUM_LINES-1:0] valid_q,    valid_d;
  logic                 mem_req_q,  mem_req_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [OFF_W-1:0]     beat_q,     beat_d;
  logic                 flushed_q,  flushed_d;

  // Storage arrays carry no reset; only the valid bits qualify their content.
  logic [31:0]      data_mem [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [NUM_LINES];

  logic [OFF_W-1:0] look_off;
  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             hit;
  logic             start_fill;

  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_we;
  logic             fill_last;

  // Byte-offset bits of the fetch address play no part in the lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.Instr_address_fIF[1:0];

  // -------------------------------------------------------------------------
  // Lookup
  // -------------------------------------------------------------------------
  assign look_off = bus.Instr_address_fIF[2 +: OFF_W];
  assign look_idx = bus.Instr_address_fIF[IDX_LSB +: IDX_W];
  assign look_tag = bus.Instr_address_fIF[TAG_LSB +: TAG_W];

  assign hit = (state_q == ST_IDLE) && valid_q[look_idx] &&
               (tag_mem[look_idx] == look_tag);

  assign bus.ICache_busy_2IF = !hit;
  assign bus.Instr1_2IF      = hit ? data_mem[{look_idx, look_off}] : 32'h0;

  // A flush in the same cycle as a miss wins; the fill starts one cycle later.
  assign start_fill = (state_q == ST_IDLE) && !hit && !bus.Flush;

  // -------------------------------------------------------------------------
  // Fill side: index/tag come from the latched line address so a redirect of
  // the fetch address mid-fill cannot corrupt the line being written.
  // -------------------------------------------------------------------------
  assign fill_idx  = mem_addr_q[IDX_LSB +: IDX_W];
  assign fill_tag  = mem_addr_q[TAG_LSB +: TAG_W];
  assign fill_we   = (state_q == ST_FILL) && bus.Mem_valid_fMEM;
  assign fill_last = fill_we && (beat_q == LAST_BEAT);

  assign bus.Mem_req_2MEM  = mem_req_q;
  assign bus.Mem_addr_2MEM = mem_addr_q;

  // -------------------------------------------------------------------------
  // FSM next-state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    beat_d     = beat_q;
    flushed_d  = flushed_q;

    case (state_q)
      ST_IDLE: begin
        if (start_fill) begin
          state_d    = ST_FILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {bus.Instr_address_fIF[31:IDX_LSB], {IDX_LSB{1'b0}}};
          beat_d     = '0;
          flushed_d  = 1'b0;
        end
      end

      ST_FILL: begin
        if (bus.Flush) begin
          flushed_d = 1'b1;
        end
        if (bus.Mem_valid_fMEM) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            // A flush seen earlier in this fill leaves the line invalid.
            if (!flushed_q) begin
              valid_d[fill_idx] = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Flush overrides everything, including a line completing on this edge.
    if (bus.Flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      beat_q     <= '0;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      beat_q     <= beat_d;
      flushed_q  <= flushed_d;
    end
  end

  // Array writes are gated by state_q, which reset forces to IDLE, so beats
  // arriving during or after reset never land in the arrays.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      data_mem[{fill_idx, beat_q}] <= bus.Mem_data_fMEM;
    end
    if (fill_last) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q  + {31'd0, hit};
    miss_cnt_d = miss_cnt_q + {31'd0, start_fill};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.Hit_count  = hit_cnt_q;
  assign bus.Miss_count = miss_cnt_q;
`else
  assign bus.Hit_count  = 32'h0;
  assign bus.Miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  icache_direct_if bus();

  icache_direct #(.LINE_WORDS(4), .NUM_LINES(64)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   stall = 0;
  int   mem_beat = 0;

  // Memory contents: the boot line holds 11111111..44444444, every other
  // word is its own address XOR 32'hDEAD0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:4] == 28'hBFC0000) begin
      case (a[3:2])
        2'd0:    w = 32'h11111111;
        2'd1:    w = 32'h22222222;
        2'd2:    w = 32'h33333333;
        default: w = 32'h44444444;
      endcase
    end else begin
      w = a ^ 32'hDEAD0000;
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory responder: answers a fill request with LINE_WORDS beats, with
  // 'stall' idle cycles after each beat.
  initial begin
    int gap;
    gap = 0;
    bus.Mem_valid_fMEM = 1'b0;
    bus.Mem_data_fMEM  = 32'h0;
    forever begin
      @(negedge CLK);
      if (!bus.Mem_req_2MEM) begin
        bus.Mem_valid_fMEM = 1'b0;
        mem_beat = 0;
        gap = 0;
      end else if (mem_beat < 4) begin
        if (gap > 0) begin
          bus.Mem_valid_fMEM = 1'b0;
          gap--;
        end else begin
          bus.Mem_valid_fMEM = 1'b1;
          bus.Mem_data_fMEM  = mem_word(bus.Mem_addr_2MEM + 32'(4 * mem_beat));
          mem_beat++;
          gap = stall;
        end
      end else begin
        bus.Mem_valid_fMEM = 1'b0;
      end
    end
  end

  // Monitor: whenever the cache presents an instruction, compare it with the
  // oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RESET && !bus.ICache_busy_2IF && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (bus.Instr1_2IF !== mon_e.data) begin
        errors++;
        $display("FAIL instr @%h: got %h expected %h", mon_e.addr, bus.Instr1_2IF, mon_e.data);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d);
    bus.Instr_address_fIF = a;
    sb_q.push_back({a, d});
  endtask

  // Waits for the monitor to consume the pending expectation and checks the
  // hit/miss behaviour observed on the way.
  task automatic wait_done(input string name, input bit exp_miss, input int exp_busy,
                           input bit chk_hold);
    int busy_n;
    bit seen_req;
    bit hold_bad;
    bit done;
    busy_n = 0; seen_req = 0; hold_bad = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge CLK); #1;
      if (sb_q.size() == 0) begin
        done = 1;
      end else begin
        busy_n++;
        if (bus.Mem_req_2MEM) seen_req = 1;
        else if (seen_req) hold_bad = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy for %0d cycles, required a response", name, busy_n);
      sb_q.delete();
    end else begin
      check({name, "_miss"}, 32'(busy_n > 0), 32'(exp_miss));
      if (exp_busy >= 0) check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      if (chk_hold) check({name, "_req_hold"}, 32'(hold_bad), 32'd0);
      check({name, "_req_idle"}, 32'(bus.Mem_req_2MEM), 32'd0);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input bit m,
                       input int bn, input string name);
    @(posedge CLK); #1;
    issue(a, d);
    wait_done(name, m, bn, m);
  endtask

  task automatic wait_beat(input int n, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK); #1;
      if (mem_beat == n) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_beat_timeout: got beat %0d required %0d", name, mem_beat, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.Instr_address_fIF = 32'hBFC00000;
    bus.Flush = 1'b0;
    RESET = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    check("rst_busy",  32'(bus.ICache_busy_2IF), 32'd1);
    check("rst_instr", bus.Instr1_2IF, 32'h0);
    check("rst_req",   32'(bus.Mem_req_2MEM), 32'd0);
    check("rst_addr",  bus.Mem_addr_2MEM, 32'h0);
    check("rst_hits",  bus.Hit_count, 32'h0);
    check("rst_miss",  bus.Miss_count, 32'h0);

    // Boot-address fill right after reset release
    issue(32'hBFC00000, 32'h11111111);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("boot_req",  32'(bus.Mem_req_2MEM), 32'd1);
    check("boot_addr", bus.Mem_addr_2MEM, 32'hBFC00000);
    check("boot_busy", 32'(bus.ICache_busy_2IF), 32'd1);
    wait_done("boot_fill", 1'b1, -1, 1'b1);

    // Remaining words of the line are hits
    fetch(32'hBFC00004, 32'h22222222, 1'b0, 0, "hit_w1");
    fetch(32'hBFC00008, 32'h33333333, 1'b0, 0, "hit_w2");
    fetch(32'hBFC0000C, 32'h44444444, 1'b0, 0, "hit_w3");

    // Stalled memory: request held across idle cycles, beats in order
    stall = 3;
    fetch(32'h00001040, 32'hDEAD1040, 1'b1, -1, "stall_fill");
    stall = 0;
    fetch(32'h00001044, 32'hDEAD1044, 1'b0, 0, "stall_w1");
    fetch(32'h00001048, 32'hDEAD1048, 1'b0, 0, "stall_w2");
    fetch(32'h0000104C, 32'hDEAD104C, 1'b0, 0, "stall_w3");

    // Aliasing lines: same index, different tag; zero-wait miss penalty
    fetch(32'hBFC00400, 32'h616D0400, 1'b1, 5, "alias_fill");
    fetch(32'hBFC00000, 32'h11111111, 1'b1, 5, "alias_refetch");

    // Flush on the second beat of a fill
    @(posedge CLK); #1;
    issue(32'h00002000, 32'hDEAD2000);
    wait_beat(2, "flush_fill");
    bus.Flush = 1'b1;
    @(posedge CLK); #1;
    bus.Flush = 1'b0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK); #1;
      if (!bus.Mem_req_2MEM) ok = 1;
    end
    check("flush_req_drop", 32'(ok), 32'd1);
    check("flush_line_invalid", 32'(bus.ICache_busy_2IF), 32'd1);
    @(posedge CLK); #1;
    check("flush_rereq",      32'(bus.Mem_req_2MEM), 32'd1);
    check("flush_rereq_addr", bus.Mem_addr_2MEM, 32'h00002000);
    wait_done("flush_refill", 1'b1, -1, 1'b0);

    // Flush in IDLE together with a miss: no fill that cycle, valid bits cleared
    @(posedge CLK); #1;
    bus.Flush = 1'b1;
    issue(32'h00002010, 32'hDEAD2010);
    @(posedge CLK); #1;
    bus.Flush = 1'b0;
    check("flush_idle_nofill", 32'(bus.Mem_req_2MEM), 32'd0);
    wait_done("flush_idle_miss", 1'b1, -1, 1'b1);
    fetch(32'h00002000, 32'hDEAD2000, 1'b1, 5, "flush_idle_inval");

    // Reset during the first beat of a fill
    @(posedge CLK); #1;
    issue(32'h00003000, 32'hDEAD3000);
    wait_beat(1, "rst_fill");
    RESET = 1'b0;
    #1;
    check("rst_mid_req_drop", 32'(bus.Mem_req_2MEM), 32'd0);
    check("rst_mid_busy",     32'(bus.ICache_busy_2IF), 32'd1);
    repeat (2) @(negedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("rst_rereq",      32'(bus.Mem_req_2MEM), 32'd1);
    check("rst_rereq_addr", bus.Mem_addr_2MEM, 32'h00003000);
`ifdef ICACHE_STATS_EN
    check("rst_stats_miss", bus.Miss_count, 32'd1);
    check("rst_stats_hit",  bus.Hit_count, 32'd0);
`else
    check("rst_stats_miss", bus.Miss_count, 32'd0);
    check("rst_stats_hit",  bus.Hit_count, 32'd0);
`endif
    wait_done("rst_refill", 1'b1, -1, 1'b1);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
